// File: rtl/cd_pkg.sv
// Shared CD-ROM data-path types: pack FSM states and FIFO geometry.
// Latency: none (types and constants only).
// Backpressure: n/a.
package cd_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        HI   = 3'd2,
        OUT  = 3'd3,
        FIN  = 3'd4
    } cd_pack_state_t;

    localparam int CD_FIFO_BYTES = 16;
    localparam int CD_WORD_BYTES = 4;

endpackage

// File: rtl/cd_dma_pack.sv
// Drains N 32-bit words from the CD byte FIFO via 16-bit pops and hands them to DMA LE-packed.
// Latency: first word valid 3 cycles after start; 3 cycles per word with out_ready held high.
// Backpressure: out_valid/out_data held in OUT until out_ready; no FIFO pops while stalled.
module cd_dma_pack
    import cd_pkg::*;
#(
    parameter int MAX_WORDS = CD_FIFO_BYTES / CD_WORD_BYTES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  len_words,
    input  logic        abort,
    input  logic [15:0] fifo_data,
    input  logic        fifo_empty,
    output logic        fifo_re16,
    output logic        fifo_clr,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic        err
);

    cd_pack_state_t state_q, state_d;
    logic [2:0]     rem_q, rem_d;
    logic [15:0]    lo_half_q, lo_half_d;
    logic [15:0]    hi_half_q, hi_half_d;
    logic           err_q, err_d;
    logic [2:0]     len_clamped;

    // Requests beyond the FIFO depth are trimmed to what the FIFO can hold.
    assign len_clamped = (32'(len_words) > MAX_WORDS) ? 3'(MAX_WORDS) : len_words;

    // State, remaining-word count, captured halves and the registered err pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rem_q     <= 3'd0;
            lo_half_q <= 16'd0;
            hi_half_q <= 16'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            lo_half_q <= lo_half_d;
            hi_half_q <= hi_half_d;
            err_q     <= err_d;
        end
    end

    // Next-state and outputs; abort overrides everything the normal flow would do.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        lo_half_d = lo_half_q;
        hi_half_d = hi_half_q;
        err_d     = 1'b0;
        fifo_re16 = 1'b0;
        fifo_clr  = 1'b0;
        out_valid = 1'b0;
        out_data  = 32'd0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // An empty FIFO at start is a producer error: no reads and no clear.
                    if (fifo_empty) begin
                        err_d = 1'b1;
                    end else if (len_clamped == 3'd0) begin
                        state_d = FIN;
                    end else begin
                        rem_d   = len_clamped;
                        state_d = LO;
                    end
                end
            end
            LO: begin
                lo_half_d = fifo_data;
                fifo_re16 = 1'b1;
                state_d   = HI;
            end
            HI: begin
                hi_half_d = fifo_data;
                fifo_re16 = 1'b1;
                state_d   = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                out_data  = {hi_half_q, lo_half_q};
                if (out_ready) begin
                    // rem saturates at zero rather than wrapping.
                    if (rem_q != 3'd0) begin
                        rem_d = rem_q - 3'd1;
                    end
                    state_d = (rem_q > 3'd1) ? LO : FIN;
                end
            end
            FIN: begin
                fifo_clr = 1'b1;
                done     = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort squashes the in-flight pop, the word and any done, and flushes the FIFO.
        if (abort && (state_q != IDLE)) begin
            state_d   = IDLE;
            rem_d     = 3'd0;
            lo_half_d = lo_half_q;
            hi_half_d = hi_half_q;
            fifo_re16 = 1'b0;
            fifo_clr  = 1'b1;
            out_valid = 1'b0;
            out_data  = 32'd0;
            done      = 1'b0;
        end
    end

    assign busy = (state_q != IDLE);
    assign err  = err_q;

endmodule

// File: tb/tb_cd_dma_pack.sv
module tb_cd_dma_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  len_words;
    logic        abort;
    logic [15:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_re16;
    logic        fifo_clr;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    cd_dma_pack dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len_words  (len_words),
        .abort      (abort),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_re16  (fifo_re16),
        .fifo_clr   (fifo_clr),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // ---------------- behavioural byte FIFO feeding the DUT ----------------
    logic [7:0] fmem [16];
    logic [3:0] frd = 4'd0;
    logic [3:0] fwr = 4'd0;
    logic [3:0] frd1;
    int         fcnt = 0;
    logic       push_vld = 1'b0;
    logic [7:0] push_dat = 8'd0;

    assign frd1       = frd + 4'd1;
    assign fifo_data  = {fmem[frd1], fmem[frd]};
    assign fifo_empty = (fcnt == 0);

    always @(posedge clk) begin
        if (rst || fifo_clr) begin
            frd  <= 4'd0;
            fwr  <= 4'd0;
            fcnt <= 0;
        end else begin
            if (fifo_re16 && fcnt >= 2) begin
                frd  <= frd + 4'd2;
                fcnt <= fcnt - 2;
            end
            if (push_vld) begin
                fmem[fwr] <= push_dat;
                fwr       <= fwr + 4'd1;
                fcnt      <= fcnt + 1;
            end
        end
    end

    // ---------------- out_ready driver ----------------
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: stall first word 5 cycles
    int stall_cnt = 0;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: out_ready = 1'($urandom_range(0, 1));
            2: begin
                if (out_valid && stall_cnt < 5) begin
                    out_ready = 1'b0;
                    stall_cnt = stall_cnt + 1;
                end else begin
                    out_ready = 1'b1;
                end
            end
            default: begin
                out_ready = 1'b1;
                stall_cnt = 0;
            end
        endcase
    end

    // ---------------- monitor ----------------
    int          cyc = 0;
    logic [31:0] got_q [$];
    int          done_q [$];
    int          clr_q [$];
    int          err_q [$];
    int          pops = 0;
    int          viol = 0;
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic [31:0] pd = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid && out_ready) got_q.push_back(out_data);
        if (fifo_re16) pops <= pops + 1;
        if (done) done_q.push_back(cyc);
        if (fifo_clr) clr_q.push_back(cyc);
        if (err) err_q.push_back(cyc);
        if ((!out_valid && out_data != 32'd0) ||
            (fifo_re16 && (out_valid || fifo_clr || done)) ||
            (done && !fifo_clr) ||
            (pv && !pr && out_valid && out_data != pd))
            viol <= viol + 1;
        pv <= out_valid;
        pr <= out_ready;
        pd <= out_data;
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] exp_b [16];

    task automatic load(input bit seq);
        for (int i = 0; i < 16; i++) begin
            push_vld = 1'b1;
            push_dat = seq ? 8'(i) : 8'($urandom);
            exp_b[i] = push_dat;
            @(posedge clk); #1;
        end
        push_vld = 1'b0;
    endtask

    // One transfer; abort_k / dup_k are cycle offsets from the first LO cycle (-1 = none).
    task automatic xfer(input int len, input int mode, input int abort_k, input int dup_k,
                        input bit seq);
        int lc, s, g0, p0, d0, c0, e0, v0, ew, ep, t;
        logic [31:0] w;
        lc = (len > 4) ? 4 : len;
        load(seq);
        rdy_mode = mode;
        g0 = got_q.size(); p0 = pops; d0 = done_q.size();
        c0 = clr_q.size(); e0 = err_q.size(); v0 = viol;
        len_words = 3'(len);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s = cyc;
        if (dup_k >= 0) begin
            repeat (dup_k) begin @(posedge clk); #1; end
            start = 1'b1;
            len_words = 3'($urandom_range(1, 7));
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (abort_k >= 0) begin
            repeat (abort_k) begin @(posedge clk); #1; end
            abort = 1'b1;
            @(negedge clk);
            check("abort_pop", 32'(fifo_re16), 0);
            check("abort_clr", 32'(fifo_clr), 1);
            check("abort_valid", 32'(out_valid), 0);
            @(posedge clk); #1;
            abort = 1'b0;
            @(negedge clk);
            check("abort_idle", 32'(busy), 0);
        end else begin
            for (t = 0; t < 300; t++) begin
                @(negedge clk);
                if (!busy) break;
            end
            check("timeout", 32'(t >= 300), 0);
        end
        repeat (3) @(posedge clk);
        #1;
        rdy_mode = 0;
        @(posedge clk); #1;

        if (abort_k >= 0) begin
            ew = abort_k / 3;
            ep = 2 * (abort_k / 3) + (abort_k % 3);
        end else begin
            ew = lc;
            ep = 2 * lc;
        end
        check("word_count", 32'(got_q.size() - g0), 32'(ew));
        for (int i = 0; i < ew && g0 + i < got_q.size(); i++) begin
            w = {exp_b[4*i+3], exp_b[4*i+2], exp_b[4*i+1], exp_b[4*i]};
            check("word", got_q[g0+i], w);
        end
        check("pops", 32'(pops - p0), 32'(ep));
        check("done_count", 32'(done_q.size() - d0), (abort_k >= 0) ? 0 : 1);
        check("clr_count", 32'(clr_q.size() - c0), 1);
        check("err_count", 32'(err_q.size() - e0), 0);
        check("invariants", 32'(viol - v0), 0);
        if (clr_q.size() > c0) begin
            if (abort_k >= 0)
                check("clr_cycle", 32'(clr_q[c0] - s), 32'(abort_k));
            else if (mode == 0)
                check("done_cycle", 32'(clr_q[c0] - s), 32'(3 * lc));
            else if (mode == 2)
                check("done_cycle", 32'(clr_q[c0] - s), 32'((lc > 0) ? 3 * lc + 5 : 0));
        end
    endtask

    task automatic err_test();
        int e0, p0, c0;
        e0 = err_q.size(); p0 = pops; c0 = clr_q.size();
        len_words = 3'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("err_pulse", 32'(err), 1);
        check("err_busy", 32'(busy), 0);
        @(negedge clk);
        check("err_single", 32'(err), 0);
        repeat (3) @(posedge clk);
        #1;
        check("err_count", 32'(err_q.size() - e0), 1);
        check("err_pops", 32'(pops - p0), 0);
        check("err_clr", 32'(clr_q.size() - c0), 0);
    endtask

    task automatic rst_test();
        int d0;
        load(1'b0);
        d0 = done_q.size();
        len_words = 3'd4;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("rst_in_out", 32'(out_valid), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_outs", {out_data}, 32'd0);
        check("rst_flags", {26'd0, out_valid, busy, done, err, fifo_clr, fifo_re16}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_no_done", 32'(done_q.size() - d0), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int len, mode, lc, ab, dp;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        len_words = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_data", out_data, 32'd0);
        check("reset_flags", {26'd0, out_valid, busy, done, err, fifo_clr, fifo_re16}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        xfer(4, 0, -1, -1, 1'b1);   // bytes 00..0F, full depth
        xfer(2, 2, -1, -1, 1'b1);   // stalled first word
        err_test();
        xfer(0, 0, -1, -1, 1'b0);   // zero length
        xfer(7, 0, -1, -1, 1'b0);   // clamped to 4
        xfer(4, 0, 4, -1, 1'b0);    // abort in HI of word 1
        rst_test();
        xfer(3, 0, -1, 2, 1'b0);    // start while busy

        for (int it = 0; it < 25; it++) begin
            len = $urandom_range(0, 7);
            lc = (len > 4) ? 4 : len;
            mode = $urandom_range(0, 2);
            if (lc == 0) mode = 0;
            ab = -1;
            dp = -1;
            if (mode == 0 && lc > 0 && $urandom_range(0, 2) == 0)
                ab = $urandom_range(0, 3 * lc - 1);
            else if (mode == 0 && $urandom_range(0, 2) == 0)
                dp = $urandom_range(0, 3 * lc);
            xfer(len, mode, ab, dp, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
